// File: rtl/portal_out_arbiter_pkg.sv
// Shared constants and helpers for the indication-portal output arbiter.
// Holds id/length widths, portal interface ids and the round-robin pick.
package portal_out_arbiter_pkg;

    localparam int IFC_ID_WIDTH = 16;
    localparam int LENGTH_WIDTH = 16;
    localparam int MAX_PORTALS  = 16;

    // Interface ids of the indication portals (IfcNames).
    localparam int IfcNamesEchoIndication = 5;
    localparam int IfcNamesEchoRequest    = 6;
    localparam int IfcNamesSwallow        = 7;

    // First set bit of req searching upward from last+1, wrapping at n.
    // Returns 0 when nothing is requested; callers qualify with any-request.
    function automatic logic [3:0] round_robin_pick(
        input logic [MAX_PORTALS-1:0] req,
        input logic [3:0]             last,
        input int                     n
    );
        logic [3:0] pick;
        logic       found;
        int         idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= n; k++) begin
            idx = (int'(last) + k) % n;
            if (!found && req[idx]) begin
                pick  = 4'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/portal_out_arbiter_rr_select.sv
// Combinational round-robin selector: request vector + last grant -> winner.
// Ports: req, lastGrant in; grantIdx, grantOneHot, anyReq out.
module portal_out_arbiter_rr_select
    import portal_out_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   lastGrant,
    output logic [IDX_W-1:0]   grantIdx,
    output logic [NUM_REQ-1:0] grantOneHot,
    output logic               anyReq
);

    always_comb begin
        anyReq      = |req;
        grantIdx    = IDX_W'(round_robin_pick(
                          MAX_PORTALS'(req), 4'(lastGrant), NUM_REQ));
        grantOneHot = '0;
        if (anyReq) begin
            grantOneHot = NUM_REQ'(1) << grantIdx;
        end
    end

endmodule

// File: rtl/portal_out_arbiter.sv
// Shares the outgoing bus adapter between NUM_PORTALS indication portals.
// Ports: CLK, RST; ind_enq__ENA/RDY/v per portal; out_enq__ENA/RDY,
// out_data (id stamped in [15:0]), out_length, out_portal (debug).
module portal_out_arbiter
    import portal_out_arbiter_pkg::*;
#(
    parameter int NUM_PORTALS = 4,
    parameter int DATA_WIDTH  = 128,
    parameter int ID_BASE     = IfcNamesEchoIndication
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic [NUM_PORTALS-1:0]            ind_enq__ENA,
    output logic [NUM_PORTALS-1:0]            ind_enq__RDY,
    input  logic [NUM_PORTALS*DATA_WIDTH-1:0] ind_enq_v,
    output logic                              out_enq__ENA,
    input  logic                              out_enq__RDY,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic [LENGTH_WIDTH-1:0]           out_length,
    output logic [$clog2((NUM_PORTALS > 1) ? NUM_PORTALS : 2)-1:0] out_portal
);

    localparam int IDX_W = $clog2((NUM_PORTALS > 1) ? NUM_PORTALS : 2);
    localparam logic [IFC_ID_WIDTH-1:0] idBase = IFC_ID_WIDTH'(ID_BASE);

    logic [NUM_PORTALS-1:0] slotFull;
    logic [DATA_WIDTH-1:0]  slotData [NUM_PORTALS];
    logic                   outValid;
    logic [IDX_W-1:0]       lastGrant;
    logic [DATA_WIDTH-1:0]  outData;
    logic [LENGTH_WIDTH-1:0] outLength;
    logic [IDX_W-1:0]       outPortal;

    logic [IDX_W-1:0]       grantIdx;
    logic [NUM_PORTALS-1:0] grantOneHot;
    logic                   anyReq;
    logic                   transfer;
    logic                   load;
    logic [NUM_PORTALS-1:0] accept;
    logic [NUM_PORTALS-1:0] clearMask;
    logic [DATA_WIDTH-1:0]  winData;
    logic [IFC_ID_WIDTH-1:0] winId;

    portal_out_arbiter_rr_select #(
        .NUM_REQ (NUM_PORTALS),
        .IDX_W   (IDX_W)
    ) uSelect (
        .req         (slotFull),
        .lastGrant   (lastGrant),
        .grantIdx    (grantIdx),
        .grantOneHot (grantOneHot),
        .anyReq      (anyReq)
    );

    // RDY comes straight from the slot flops: no input-to-RDY path.
    assign ind_enq__RDY = ~slotFull;
    assign out_enq__ENA = outValid;
    assign out_data     = outData;
    assign out_length   = outLength;
    assign out_portal   = outPortal;

    always_comb begin
        transfer  = outValid && out_enq__RDY;
        load      = (!outValid || transfer) && anyReq;
        accept    = ind_enq__ENA & ~slotFull;
        clearMask = '0;
        if (load) begin
            clearMask = grantOneHot;
        end
        winData = slotData[grantIdx];
        winId   = idBase + IFC_ID_WIDTH'(grantIdx);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            slotFull  <= '0;
            outValid  <= 1'b0;
            lastGrant <= IDX_W'(NUM_PORTALS - 1);
            outData   <= '0;
            outLength <= '0;
            outPortal <= '0;
        end else begin
            // A loaded slot is never accepting (it was full), so the
            // clear and set masks never overlap.
            slotFull <= (slotFull & ~clearMask) | accept;
            if (load) begin
                outValid  <= 1'b1;
                outData   <= {winData[DATA_WIDTH-1:IFC_ID_WIDTH], winId};
                outLength <= winData[LENGTH_WIDTH-1:0];
                outPortal <= grantIdx;
                lastGrant <= grantIdx;
            end else if (transfer) begin
                outValid <= 1'b0;
            end
        end
    end

    // Slot payload only matters while its full flag is set.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NUM_PORTALS; i++) begin
            if (accept[i]) begin
                slotData[i] <= ind_enq_v[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_portal_out_arbiter.sv
// Self-checking bench for portal_out_arbiter (4 portals, 128-bit, id base 5).
// Directed scenarios plus a randomized run against a behavioural model.
module tb_portal_out_arbiter;

    localparam int N  = 4;
    localparam int DW = 128;
    localparam int IB = 5;

    logic          CLK;
    logic          RST;
    logic [N-1:0]  ena;
    logic [N-1:0]  rdy;
    logic [N*DW-1:0] v;
    logic          outEna;
    logic          outRdy;
    logic [DW-1:0] outData;
    logic [15:0]   outLength;
    logic [1:0]    outPortal;

    int total = 0;
    int bad   = 0;

    logic [1:0]    obsPortal [$];
    logic [DW-1:0] obsData   [$];

    portal_out_arbiter #(
        .NUM_PORTALS (N),
        .DATA_WIDTH  (DW),
        .ID_BASE     (IB)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .ind_enq__ENA (ena),
        .ind_enq__RDY (rdy),
        .ind_enq_v    (v),
        .out_enq__ENA (outEna),
        .out_enq__RDY (outRdy),
        .out_data     (outData),
        .out_length   (outLength),
        .out_portal   (outPortal)
    );

    always #5 CLK = ~CLK;

    // Record every transfer the adapter would accept at the next edge.
    always @(negedge CLK) begin
        if (RST === 1'b0 && outEna === 1'b1 && outRdy === 1'b1) begin
            obsPortal.push_back(outPortal);
            obsData.push_back(outData);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [DW-1:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic set_v(input int i, input logic [DW-1:0] val);
        v[i*DW +: DW] = val;
    endtask

    function automatic logic [DW-1:0] expect_out(input int p,
                                                 input logic [DW-1:0] msg);
        logic [15:0] id;
        id = 16'(IB + p);
        return {msg[DW-1:16], id};
    endfunction

    task automatic do_reset();
        ena = '0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST    = 1'b1;
        outRdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ena = 4'(1 << i) | 4'b1000;
            set_v(i, rand128());
            tick();
            total++;
            if (outEna !== 1'b0) begin
                bad++;
                $display("FAIL reset_ena cyc%0d got=%b want=0", i, outEna);
            end
        end
        ena = '0;
        RST = 1'b0;
        tick();
        total++;
        if (rdy !== 4'hF) begin
            bad++;
            $display("FAIL reset_rdy got=%b want=1111", rdy);
        end
        total++;
        if (outEna !== 1'b0 || outData !== '0 || outLength !== 16'h0 ||
            outPortal !== 2'd0) begin
            bad++;
            $display("FAIL reset_out got=%b/%h/%h/%0d want=0/0/0/0",
                     outEna, outData, outLength, outPortal);
        end
        repeat (3) tick();
        total++;
        if (obsData.size() != 0) begin
            bad++;
            $display("FAIL reset_emit got=%0d want=0", obsData.size());
        end
    endtask

    task automatic test_single();
        logic [DW-1:0] m;
        obsData.delete();
        obsPortal.delete();
        m = rand128();
        m[15:0] = 16'h0003;
        set_v(2, m);
        ena = 4'b0100;
        tick();
        ena = '0;
        total++;
        if (outEna !== 1'b0) begin
            bad++;
            $display("FAIL single_early got=%b want=0", outEna);
        end
        tick();
        total++;
        if (outEna !== 1'b1 || outData !== expect_out(2, m) ||
            outLength !== 16'h3 || outPortal !== 2'd2) begin
            bad++;
            $display("FAIL single_out got=%b/%h/%h/%0d want=1/%h/3/2",
                     outEna, outData, outLength, outPortal, expect_out(2, m));
        end
        tick();
        total++;
        if (outEna !== 1'b0 || obsData.size() != 1) begin
            bad++;
            $display("FAIL single_once got=%b/%0d want=0/1",
                     outEna, obsData.size());
        end
    endtask

    task automatic test_contention();
        logic [DW-1:0] m [N];
        do_reset();
        outRdy = 1'b1;
        for (int i = 0; i < N; i++) begin
            m[i] = rand128();
            set_v(i, m[i]);
        end
        ena = 4'hF;
        tick();
        ena = '0;
        tick();
        for (int k = 0; k < N; k++) begin
            total++;
            if (outEna !== 1'b1 || outPortal !== 2'(k) ||
                outData !== expect_out(k, m[k])) begin
                bad++;
                $display("FAIL contend_%0d got=%b/%0d/%h want=1/%0d/%h",
                         k, outEna, outPortal, outData, k, expect_out(k, m[k]));
            end
            tick();
        end
        total++;
        if (outEna !== 1'b0) begin
            bad++;
            $display("FAIL contend_drain got=%b want=0", outEna);
        end
        m[0] = rand128();
        m[3] = rand128();
        set_v(0, m[0]);
        set_v(3, m[3]);
        ena = 4'b1001;
        tick();
        ena = '0;
        tick();
        total++;
        if (outEna !== 1'b1 || outPortal !== 2'd0 ||
            outData !== expect_out(0, m[0])) begin
            bad++;
            $display("FAIL contend_wrap0 got=%b/%0d want=1/0",
                     outEna, outPortal);
        end
        tick();
        total++;
        if (outEna !== 1'b1 || outPortal !== 2'd3 ||
            outData !== expect_out(3, m[3])) begin
            bad++;
            $display("FAIL contend_wrap3 got=%b/%0d want=1/3",
                     outEna, outPortal);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] m1;
        logic [DW-1:0] m2;
        logic [DW-1:0] snapData;
        logic [15:0]   snapLen;
        obsData.delete();
        obsPortal.delete();
        outRdy = 1'b0;
        m1 = rand128();
        m2 = rand128();
        set_v(1, m1);
        set_v(2, m2);
        ena = 4'b0110;
        tick();
        ena = '0;
        tick();
        total++;
        if (outEna !== 1'b1 || outPortal !== 2'd1 || rdy[1] !== 1'b1 ||
            rdy[2] !== 1'b0) begin
            bad++;
            $display("FAIL bp_load got=%b/%0d/%b want=1/1/x01x",
                     outEna, outPortal, rdy);
        end
        snapData = outData;
        snapLen  = outLength;
        for (int c = 0; c < 10; c++) begin
            tick();
            total++;
            if (outEna !== 1'b1 || outData !== snapData ||
                outLength !== snapLen || outPortal !== 2'd1 ||
                outData !== expect_out(1, m1)) begin
                bad++;
                $display("FAIL bp_hold c%0d got=%b/%0d/%h want=1/1/%h",
                         c, outEna, outPortal, outData, expect_out(1, m1));
            end
        end
        outRdy = 1'b1;
        tick();
        total++;
        if (outEna !== 1'b1 || outPortal !== 2'd2 ||
            outData !== expect_out(2, m2) || outLength !== m2[15:0]) begin
            bad++;
            $display("FAIL bp_b2b got=%b/%0d/%h want=1/2/%h",
                     outEna, outPortal, outData, expect_out(2, m2));
        end
        tick();
        total++;
        if (outEna !== 1'b0 || obsData.size() != 2) begin
            bad++;
            $display("FAIL bp_count got=%b/%0d want=0/2",
                     outEna, obsData.size());
        end
    endtask

    task automatic test_ignored();
        logic [DW-1:0] ma;
        logic [DW-1:0] m0a;
        logic [DW-1:0] m0b;
        int n0;
        obsData.delete();
        obsPortal.delete();
        outRdy = 1'b0;
        ma  = rand128();
        m0a = rand128();
        m0b = ~m0a;
        set_v(1, ma);
        ena = 4'b0010;
        tick();
        ena = '0;
        tick();
        set_v(0, m0a);
        ena = 4'b0001;
        tick();
        total++;
        if (rdy[0] !== 1'b0) begin
            bad++;
            $display("FAIL ign_full got=%b want=0", rdy[0]);
        end
        set_v(0, m0b);
        tick();
        ena = '0;
        tick();
        outRdy = 1'b1;
        repeat (4) tick();
        n0 = 0;
        foreach (obsPortal[k]) begin
            if (obsPortal[k] == 2'd0) n0++;
        end
        total++;
        if (n0 != 1 || obsData.size() != 2) begin
            bad++;
            $display("FAIL ign_count got=%0d/%0d want=1/2",
                     n0, obsData.size());
        end else begin
            total++;
            if (obsPortal[1] !== 2'd0 || obsData[1] !== expect_out(0, m0a)) begin
                bad++;
                $display("FAIL ign_data got=%0d/%h want=0/%h",
                         obsPortal[1], obsData[1], expect_out(0, m0a));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] m0;
        logic [DW-1:0] m2;
        outRdy = 1'b0;
        for (int i = 1; i < N; i++) set_v(i, rand128());
        ena = 4'b1110;
        tick();
        ena = '0;
        tick();
        total++;
        if (outEna !== 1'b1) begin
            bad++;
            $display("FAIL rmid_pre got=%b want=1", outEna);
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        obsData.delete();
        obsPortal.delete();
        outRdy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            total++;
            if (outEna !== 1'b0 || rdy !== 4'hF) begin
                bad++;
                $display("FAIL rmid_idle c%0d got=%b/%b want=0/1111",
                         c, outEna, rdy);
            end
            tick();
        end
        total++;
        if (obsData.size() != 0) begin
            bad++;
            $display("FAIL rmid_emit got=%0d want=0", obsData.size());
        end
        m0 = rand128();
        m2 = rand128();
        set_v(0, m0);
        set_v(2, m2);
        ena = 4'b0101;
        tick();
        ena = '0;
        tick();
        total++;
        if (outEna !== 1'b1 || outPortal !== 2'd0 ||
            outData !== expect_out(0, m0)) begin
            bad++;
            $display("FAIL rmid_first got=%b/%0d want=1/0", outEna, outPortal);
        end
        tick();
        total++;
        if (outEna !== 1'b1 || outPortal !== 2'd2 ||
            outData !== expect_out(2, m2)) begin
            bad++;
            $display("FAIL rmid_second got=%b/%0d want=1/2", outEna, outPortal);
        end
        tick();
    endtask

    // Behavioural model: each portal holds at most one message; the output
    // register takes the next full portal in rotating order whenever it is
    // empty or being drained.
    task automatic test_random();
        bit            mFull [N];
        logic [DW-1:0] mSlot [N];
        bit            mValid;
        logic [DW-1:0] mData;
        logic [15:0]   mLen;
        int            mPortal;
        int            mLast;
        int            w;
        bit            xfer;
        logic [N-1:0]  e;
        logic [DW-1:0] nv [N];
        do_reset();
        for (int i = 0; i < N; i++) mFull[i] = 0;
        mValid  = 0;
        mData   = '0;
        mLen    = '0;
        mPortal = 0;
        mLast   = N - 1;
        for (int c = 0; c < 400; c++) begin
            e      = 4'($urandom_range(0, 15));
            outRdy = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                nv[i] = rand128();
                set_v(i, nv[i]);
            end
            ena  = e;
            xfer = mValid && outRdy;
            w    = -1;
            for (int k = 1; k <= N; k++) begin
                if (w < 0 && mFull[(mLast + k) % N]) w = (mLast + k) % N;
            end
            if ((!mValid || xfer) && w >= 0) begin
                mValid   = 1;
                mData    = expect_out(w, mSlot[w]);
                mLen     = mSlot[w][15:0];
                mPortal  = w;
                mLast    = w;
                mFull[w] = 0;
                for (int i = 0; i < N; i++) begin
                    if (e[i] && !mFull[i] && i != w) begin
                        mFull[i] = 1;
                        mSlot[i] = nv[i];
                    end
                end
            end else begin
                if (xfer) mValid = 0;
                for (int i = 0; i < N; i++) begin
                    if (e[i] && !mFull[i]) begin
                        mFull[i] = 1;
                        mSlot[i] = nv[i];
                    end
                end
            end
            tick();
            total++;
            if (rdy !== ~{mFull[3], mFull[2], mFull[1], mFull[0]} ||
                outEna !== mValid) begin
                bad++;
                $display("FAIL rand_ctl c%0d got=%b/%b want=%b/%b", c, rdy,
                         outEna, ~{mFull[3], mFull[2], mFull[1], mFull[0]},
                         mValid);
            end
            if (mValid) begin
                total++;
                if (outData !== mData || outLength !== mLen ||
                    outPortal !== 2'(mPortal)) begin
                    bad++;
                    $display("FAIL rand_out c%0d got=%h/%h/%0d want=%h/%h/%0d",
                             c, outData, outLength, outPortal,
                             mData, mLen, mPortal);
                end
            end
        end
        ena    = '0;
        outRdy = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        CLK    = 1'b0;
        RST    = 1'b1;
        ena    = '0;
        v      = '0;
        outRdy = 1'b1;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_ignored();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
